// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode and serializer state encodings, legal
// frame widths, and the parity resolution used by both TX and RX sides.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } par_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    // Encodings 5..7 are reserved and behave as "no parity".
    function automatic logic par_enabled(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    // x is the XOR of all data bits of the frame.
    function automatic logic par_resolve(input logic [2:0] mode, input logic x);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_EVEN:  p = x;
            PAR_ODD:   p = ~x;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_serializer.sv
// Serialises one data word LSB-first per baud tick and appends the selected
// parity bit; feeds the start/stop framer of the UART transmitter.
module parity_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        par_mode,
    output logic              bit_out,
    output logic              busy,
    output logic              parity,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic [2:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               bit_out_q, bit_out_d;
    logic               parity_q, parity_d;
    logic               done_q, done_d;

    logic               last_bit;
    logic               x_final;

    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    assign x_final  = acc_q ^ sreg_q[0];

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        bit_out_d = bit_out_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_out_d = 1'b1;
                // A tick on the accepting edge is deliberately not consumed.
                if (in_valid) begin
                    sreg_d    = in_data;
                    mode_d    = par_mode;
                    cnt_d     = '0;
                    acc_d     = 1'b0;
                    bit_out_d = in_data[0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    acc_d  = x_final;
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (!last_bit) begin
                        bit_out_d = sreg_q[1];
                    end else if (par_enabled(mode_q)) begin
                        parity_d  = par_resolve(mode_q, x_final);
                        bit_out_d = par_resolve(mode_q, x_final);
                        state_d   = ST_PAR;
                    end else begin
                        parity_d  = 1'b0;
                        bit_out_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    bit_out_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                bit_out_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            mode_q    <= PAR_NONE;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            bit_out_q <= 1'b1;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            bit_out_q <= bit_out_d;
            parity_q  <= parity_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign bit_out  = bit_out_q;
    assign parity   = parity_q;
    assign done     = done_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: DATA_W=8 and DATA_W=7 instances share stimulus,
// a frame-level model is compared every cycle, plus hand-computed literals.
module tb_parity_serializer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       in_valid;
    logic [8:0] din;
    logic [2:0] par_mode;

    logic rdy8, bo8, busy8, par8, done8;
    logic rdy7, bo7, busy7, par7, done7;

    int n_tests;
    int n_fail;

    parity_serializer #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(din[7:0]), .par_mode(par_mode), .bit_out(bo8), .busy(busy8),
        .parity(par8), .done(done8)
    );

    parity_serializer #(.DATA_W(7)) u7 (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(rdy7),
        .in_data(din[6:0]), .par_mode(par_mode), .bit_out(bo7), .busy(busy7),
        .parity(par7), .done(done7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: at accept the whole bit list of the frame is built from the
    // word and mode; each tick consumes one entry.
    int   w_of [2] = '{8, 7};
    logic m_active [2];
    int   m_pos [2];
    int   m_nb [2];
    logic m_bits [2][10];
    logic m_pv [2];
    logic e_bit [2];
    logic e_par [2];
    logic e_done [2];
    logic model_ok;
    int   ones;
    logic has_par;

    initial begin
        model_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            e_bit[i]    = 1'b1;
            e_par[i]    = 1'b0;
            e_done[i]   = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) model_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_done[i] = 1'b0;
            if (rst) begin
                m_active[i] = 1'b0;
                e_bit[i]    = 1'b1;
                e_par[i]    = 1'b0;
            end else if (!m_active[i]) begin
                e_bit[i] = 1'b1;
                if (in_valid) begin
                    ones = 0;
                    for (int j = 0; j < w_of[i]; j++) begin
                        ones += int'(din[j]);
                        m_bits[i][j] = din[j];
                    end
                    has_par = (par_mode >= 3'd1) && (par_mode <= 3'd4);
                    case (par_mode)
                        3'd1:    m_pv[i] = (ones % 2) == 1;
                        3'd2:    m_pv[i] = (ones % 2) == 0;
                        3'd3:    m_pv[i] = 1'b1;
                        default: m_pv[i] = 1'b0;
                    endcase
                    m_bits[i][w_of[i]] = m_pv[i];
                    m_nb[i]     = w_of[i] + (has_par ? 1 : 0);
                    m_pos[i]    = 0;
                    m_active[i] = 1'b1;
                    e_bit[i]    = m_bits[i][0];
                end
            end else if (tick) begin
                m_pos[i]++;
                if (m_pos[i] == w_of[i]) e_par[i] = m_pv[i];
                if (m_pos[i] == m_nb[i]) begin
                    m_active[i] = 1'b0;
                    e_done[i]   = 1'b1;
                    e_bit[i]    = 1'b1;
                end else begin
                    e_bit[i] = m_bits[i][m_pos[i]];
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            check("u8.bit_out",  bo8,   e_bit[0]);
            check("u8.parity",   par8,  e_par[0]);
            check("u8.done",     done8, e_done[0]);
            check("u8.in_ready", rdy8,  !m_active[0]);
            check("u8.busy",     busy8, m_active[0]);
            check("u7.bit_out",  bo7,   e_bit[1]);
            check("u7.parity",   par7,  e_par[1]);
            check("u7.done",     done7, e_done[1]);
            check("u7.in_ready", rdy7,  !m_active[1]);
            check("u7.busy",     busy7, m_active[1]);
        end
    end

    // Snapshots taken after the accept (index 0) and after tick k (index k).
    logic r8 [10], d8 [10], p8 [10];
    logic r7 [10], d7 [10], p7 [10];

    task automatic rec(input int k);
        r8[k] = bo8; d8[k] = done8; p8[k] = par8;
        r7[k] = bo7; d7[k] = done7; p7[k] = par7;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic accept(input logic [8:0] d, input logic [2:0] m);
        din      = d;
        par_mode = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_ticks(input int first, input int nt);
        for (int k = first; k <= nt; k++) begin
            repeat (15) @(negedge clk);
            pulse_tick();
            rec(k);
        end
    endtask

    task automatic run_frame(input logic [8:0] d, input logic [2:0] m, input int nt);
        accept(d, m);
        rec(0);
        run_ticks(1, nt);
    endtask

    task automatic check_a5_even();
        logic exp_bits [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++)
            check($sformatf("a5_even.bit%0d", k), r8[k], exp_bits[k]);
        check("a5_even.no_done_early", d8[8], 1'b0);
        check("a5_even.done",          d8[9], 1'b1);
        check("a5_even.parity",        p8[9], 1'b0);
        check("a5_even.idle_high",     r8[9], 1'b1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        par_mode = '0;
        repeat (3) @(negedge clk);
        check("reset.bit_out",  bo8,   1'b1);
        check("reset.in_ready", rdy8,  1'b1);
        check("reset.busy",     busy8, 1'b0);
        check("reset.parity",   par8,  1'b0);
        check("reset.done",     done8, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(9'h0A5, 3'd1, 9);
        check_a5_even();

        run_frame(9'h007, 3'd2, 9);
        check("07_odd.bit0", r8[0], 1'b1);
        check("07_odd.bit2", r8[2], 1'b1);
        check("07_odd.bit3", r8[3], 1'b0);
        check("07_odd.parbit", r8[8], 1'b0);
        check("07_odd.parity", p8[9], 1'b0);
        check("07_odd.done",   d8[9], 1'b1);

        run_frame(9'h007, 3'd1, 9);
        check("07_even.parbit", r8[8], 1'b1);
        check("07_even.parity", p8[9], 1'b1);

        run_frame(9'h000, 3'd3, 9);
        check("w7_mark.parbit", r7[7], 1'b1);
        check("w7_mark.done",   d7[8], 1'b1);
        check("w7_mark.parity", p7[8], 1'b1);

        run_frame(9'h000, 3'd0, 8);
        check("w7_none.no_done_early", d7[6], 1'b0);
        check("w7_none.done",          d7[7], 1'b1);
        check("w7_none.parity",        p7[7], 1'b0);

        run_frame(9'h000, 3'd3, 9);
        run_frame(9'h000, 3'd6, 8);
        check("w7_mode6.done",   d7[7], 1'b1);
        check("w7_mode6.parity", p7[7], 1'b0);

        run_frame(9'h000, 3'd4, 9);
        check("w7_space.parbit", r7[7], 1'b0);
        check("w7_space.parity", p7[8], 1'b0);
        check("w7_space.done",   d7[8], 1'b1);

        // Back-to-back: 0x3C even, then 0x5E even presented while busy.
        accept(9'h03C, 3'd1);
        run_ticks(1, 8);
        repeat (3) @(negedge clk);
        din      = 9'h05E;
        par_mode = 3'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b.busy_no_accept", rdy8, 1'b0);
        check("b2b.hold_parbit",    bo8,  1'b0);
        repeat (10) @(negedge clk);
        check("b2b.hold_parbit2",   bo8,  1'b0);
        tick = 1'b1;
        @(negedge clk);
        check("b2b.done",       done8, 1'b1);
        check("b2b.ready_done", rdy8,  1'b1);
        @(negedge clk);
        tick     = 1'b0;
        in_valid = 1'b0;
        check("b2b.accepted",  busy8, 1'b1);
        check("b2b.first_bit", bo8,   1'b0);
        check("b2b.done_once", done8, 1'b0);
        repeat (15) @(negedge clk);
        check("b2b.no_shift_on_accept", bo8, 1'b0);
        pulse_tick();
        check("b2b.bit1", bo8, 1'b1);
        run_ticks(2, 8);
        check("b2b.parbit", r8[8], 1'b1);
        run_ticks(9, 9);
        check("b2b.done2",  d8[9], 1'b1);
        check("b2b.parity", p8[9], 1'b1);
        repeat (2) @(negedge clk);

        // Reset mid-frame.
        accept(9'h0A5, 3'd1);
        run_ticks(1, 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.bit_out",  bo8,   1'b1);
        check("rst_mid.in_ready", rdy8,  1'b1);
        check("rst_mid.parity",   par8,  1'b0);
        check("rst_mid.done",     done8, 1'b0);
        repeat (20) @(negedge clk);

        // Reset coincident with tick.
        accept(9'h007, 3'd2);
        run_ticks(1, 3);
        repeat (15) @(negedge clk);
        tick = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        check("rst_tick.bit_out",  bo8,   1'b1);
        check("rst_tick.in_ready", rdy8,  1'b1);
        check("rst_tick.done",     done8, 1'b0);
        check("rst_tick.u7_ready", rdy7,  1'b1);
        repeat (3) @(negedge clk);

        run_frame(9'h0A5, 3'd1, 9);
        check_a5_even();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
